fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 The block SHALL have parameter IF_BASE_ADDR, default 32'h1000_0000, meaning reset PC and lowest fetchable address.
REQ-003 The block SHALL have parameter IF_MAX_ADDR, default 32'h1000_3FFF, meaning highest fetchable byte address.
REQ-004 The block SHALL have parameter IF_INC, default 4, meaning sequential PC increment.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (clock), rst input 1 (synchronous active-high reset).
REQ-006 The block SHALL have these memory ports: mem_req_o output 1 (request valid); mem_addr_o output XLEN (word address); mem_gnt_i input 1 (request accepted); mem_rvalid_i input 1 (read data valid); mem_rdata_i input XLEN (instruction word).
REQ-007 The block SHALL have these redirect ports: redirect_i input 1 (branch/trap/flush); redirect_addr_i input XLEN (new PC).
REQ-008 The block SHALL have these decoder ports: if_valid_o output 1; if_ready_i input 1; if_instr_o output XLEN; if_pc_o output XLEN.
REQ-009 The block SHALL have these status ports: if_fault_o output 1 (fetch address fault); if_fault_addr_o output XLEN; if_wait_o output 1 (wait-cycle pulse for the WAIT perf counter).

Function
REQ-010 The block SHALL keep at most one memory request outstanding; responses return in order.
REQ-011 The block SHALL contain a 2-entry FIFO of {pc, instr}; if_valid_o = FIFO non-empty; the head is presented; a pop occurs when if_valid_o && if_ready_i.
REQ-012 The block SHALL use states FETCH, WAIT, DROP and FAULT.
REQ-013 In FETCH, mem_req_o SHALL be 1 when FIFO count < 2 (credit), with mem_addr_o = pc; on mem_gnt_i the state SHALL go to WAIT.
REQ-014 mem_req_o and mem_addr_o SHALL stay stable until granted; there SHALL be no request outside FETCH.
REQ-015 In WAIT, on mem_rvalid_i the block SHALL push {pc, mem_rdata_i}, set pc += IF_INC, and go to FETCH; if_wait_o SHALL be 1 in each WAIT cycle without mem_rvalid_i.
REQ-016 A push and a pop in the same cycle SHALL leave the count unchanged; a push into a full FIFO is impossible by the credit rule.
REQ-017 On redirect_i, the FIFO SHALL flush (if_valid_o = 0 next cycle) and pc SHALL become redirect_addr_i; redirect_i SHALL have priority over all other events.
REQ-018 Redirect in FETCH without grant: state SHALL stay FETCH at the new pc.
REQ-019 Redirect in FETCH with mem_gnt_i in the same cycle, or in WAIT without mem_rvalid_i: state SHALL go to DROP.
REQ-020 Redirect in WAIT with mem_rvalid_i in the same cycle: the data SHALL be discarded and state SHALL go to FETCH.
REQ-021 In DROP, the next mem_rvalid_i SHALL be discarded (no push, pc unchanged), then state SHALL go to FETCH; a redirect in DROP SHALL update pc and remain in DROP.
REQ-022 Before any request is issued, an address SHALL be legal if IF_BASE_ADDR <= addr <= IF_MAX_ADDR-3 and addr[1:0] == 0; an illegal pc (redirect target or sequential increment) SHALL enter FAULT instead of requesting.
REQ-023 In FAULT, if_fault_o SHALL be 1 and if_fault_addr_o SHALL hold the offending pc; the FIFO SHALL still drain; only redirect_i SHALL exit (to FETCH, or back to FAULT if the target is illegal).
REQ-024 Sequential increment past IF_MAX_ADDR SHALL NOT wrap.
REQ-025 if_fault_o SHALL be 0 and if_fault_addr_o SHALL be 0 outside FAULT.

Reset
REQ-026 While rst = 1 at a clk edge: pc = IF_BASE_ADDR, state = FETCH, FIFO empty, and the DROP flag cleared.
REQ-027 During reset, mem_req_o, if_valid_o, if_fault_o and if_wait_o SHALL be 0, and if_instr_o, if_pc_o, if_fault_addr_o and mem_addr_o SHALL be 0.
REQ-028 The first cycle after reset release SHALL have mem_req_o = 1 and mem_addr_o = 32'h1000_0000.
REQ-029 Reset mid-transaction SHALL abandon the outstanding response; the memory model is reset alongside.

Verification
REQ-030 Zero-wait memory with if_ready_i = 1 -> instructions appear with pc 0x1000_0000, 0x1000_0004, 0x1000_0008 in order, one per grant/response pair.
REQ-031 if_ready_i = 0 for 10 cycles -> exactly 2 entries are buffered, then mem_req_o = 0; on release, pcs are delivered in order with no loss or duplication.
REQ-032 redirect_i to 0x1000_0100 while in WAIT, with the stale rvalid 3 cycles later -> the stale word is not delivered and the next if_pc_o = 0x1000_0100.
REQ-033 Redirect coincident with mem_rvalid_i, and separately with mem_gnt_i -> neither stale word is pushed, and the next delivered pc is the redirect target.
REQ-034 Redirect to 0x1000_3FFC, then fetch continues -> 0x1000_3FFC is delivered, then if_fault_o = 1 with if_fault_addr_o = 0x1000_4000 and no further requests.
REQ-035 Redirect to 0x1000_0002 -> FAULT with if_fault_addr_o = 0x1000_0002; a subsequent redirect to 0x1000_0000 -> normal fetch resumes.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: single-outstanding memory fetch, 2-entry {pc, instr} buffer, redirect and address-fault handling
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] IF_BASE_ADDR = 32'h1000_0000,
    parameter logic [XLEN-1:0] IF_MAX_ADDR  = 32'h1000_3FFF,
    parameter int              IF_INC       = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic            if_fault_o,
    output logic [XLEN-1:0] if_fault_addr_o,
    output logic            if_wait_o
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DROP,
        S_FAULT
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN:0]   pc_inc;

    logic [XLEN-1:0] fifo_pc    [2];
    logic [XLEN-1:0] fifo_instr [2];
    logic            head;
    logic [1:0]      count;
    logic            wr_idx;

    logic            req;
    logic            granted;
    logic            push;
    logic            pop;
    logic            flush;
    logic            valid;
    logic            redirect_ok;

    // One extra bit so a sequential step past the top of the address space
    // is seen as illegal instead of wrapping back into the window.
    function automatic logic is_legal(input logic [XLEN:0] addr);
        return (addr >= {1'b0, IF_BASE_ADDR}) &&
               (addr <= ({1'b0, IF_MAX_ADDR} - (XLEN+1)'(3))) &&
               (addr[1:0] == 2'b00);
    endfunction

    assign pc_inc      = {1'b0, pc} + (XLEN+1)'(IF_INC);
    assign valid       = (count != 2'd0);
    assign wr_idx      = head ^ count[0];
    assign redirect_ok = is_legal({1'b0, redirect_addr_i});

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        req        = (state == S_FETCH) && (count < 2'd2) && is_legal({1'b0, pc});
        granted    = req && mem_gnt_i;

        if (redirect_i) begin
            flush   = 1'b1;
            pc_next = redirect_addr_i;
            case (state)
                S_FETCH: state_next = granted ? S_DROP : (redirect_ok ? S_FETCH : S_FAULT);
                // A response arriving with the redirect settles the outstanding
                // request, so there is nothing left to drop.
                S_WAIT,
                S_DROP:  state_next = mem_rvalid_i ? (redirect_ok ? S_FETCH : S_FAULT) : S_DROP;
                default: state_next = redirect_ok ? S_FETCH : S_FAULT;
            endcase
        end else begin
            case (state)
                S_FETCH: begin
                    if (!is_legal({1'b0, pc})) begin
                        state_next = S_FAULT;
                    end else if (granted) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        push       = 1'b1;
                        pc_next    = pc_inc[XLEN-1:0];
                        state_next = is_legal(pc_inc) ? S_FETCH : S_FAULT;
                    end
                end
                S_DROP: begin
                    if (mem_rvalid_i) begin
                        state_next = is_legal({1'b0, pc}) ? S_FETCH : S_FAULT;
                    end
                end
                default: state_next = S_FAULT;
            endcase
        end

        pop = valid && if_ready_i && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= IF_BASE_ADDR;
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (flush) begin
                head  <= 1'b0;
                count <= 2'd0;
            end else begin
                head <= head ^ pop;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_idx]    <= pc;
            fifo_instr[wr_idx] <= mem_rdata_i;
        end
    end

    assign mem_req_o       = !rst && req;
    assign mem_addr_o      = rst ? '0 : pc;
    assign if_valid_o      = !rst && valid;
    assign if_instr_o      = if_valid_o ? fifo_instr[head] : '0;
    assign if_pc_o         = if_valid_o ? fifo_pc[head] : '0;
    assign if_fault_o      = !rst && (state == S_FAULT);
    assign if_fault_addr_o = if_fault_o ? pc : '0;
    assign if_wait_o       = !rst && (state == S_WAIT) && !mem_rvalid_i;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a memory model and an expected-pc-stream model
module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] MAXA = 32'h1000_3FFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_fault_o;
    logic [31:0] if_fault_addr_o;
    logic        if_wait_o;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .if_valid_o      (if_valid_o),
        .if_ready_i      (if_ready_i),
        .if_instr_o      (if_instr_o),
        .if_pc_o         (if_pc_o),
        .if_fault_o      (if_fault_o),
        .if_fault_addr_o (if_fault_addr_o),
        .if_wait_o       (if_wait_o)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc = BASE;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    logic [31:0] delivered[$];
    logic        gnt_en = 1'b1;
    int          lat = 0;
    int          n0;

    logic        m_pending = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'h0;
    logic        m_gs, m_rs;
    logic [31:0] m_as;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic legal(input logic [31:0] a);
        return (a >= BASE) && (a <= MAXA - 32'd3) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] dget(input int i);
        if (i < delivered.size()) return delivered[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Memory: grants when idle, answers each grant after 'lat' extra cycles.
    initial begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            m_gs = mem_req_o && mem_gnt_i;
            m_rs = mem_rvalid_i;
            m_as = mem_addr_o;
            @(posedge clk);
            #1;
            if (rst) begin
                m_pending = 1'b0;
            end else begin
                if (m_rs) m_pending = 1'b0;
                if (m_gs) begin
                    m_pending = 1'b1;
                    m_addr    = m_as;
                    m_cnt     = lat;
                end else if (m_pending && m_cnt > 0) begin
                    m_cnt--;
                end
            end
            mem_rvalid_i = m_pending && (m_cnt == 0);
            mem_rdata_i  = mem_rvalid_i ? word_of(m_addr) : 32'h0;
            mem_gnt_i    = gnt_en && !m_pending && !rst;
        end
    end

    // Model: the decoder must see one unbroken pc stream that restarts at each redirect target.
    task automatic monitor();
        if (rst) begin
            exp_pc    = BASE;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("req_hold", {31'b0, mem_req_o}, 32'd1);
                check("addr_hold", mem_addr_o, hold_addr);
            end
            if (redirect_i) begin
                exp_pc = redirect_addr_i;
            end else if (if_valid_o && if_ready_i) begin
                check("deliver_pc", if_pc_o, exp_pc);
                check("deliver_instr", if_instr_o, word_of(exp_pc));
                delivered.push_back(if_pc_o);
                exp_pc = exp_pc + 32'd4;
            end
            if (mem_req_o) begin
                check("req_legal", {31'b0, legal(mem_addr_o)}, 32'd1);
                check("req_nofault", {31'b0, if_fault_o}, 32'd0);
            end
            if (!legal(exp_pc) && !if_valid_o && !redirect_i)
                check("illegal_noreq", {31'b0, mem_req_o}, 32'd0);
            if (!if_fault_o)
                check("fault_addr_zero", if_fault_addr_o, 32'd0);
            else if (!if_valid_o && !redirect_i)
                check("fault_addr", if_fault_addr_o, exp_pc);
            hold_prev = mem_req_o && !mem_gnt_i && !redirect_i;
            hold_addr = mem_addr_o;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant();
        for (int k = 0; k < 50; k++) begin
            if (mem_req_o && mem_gnt_i) break;
            cycle();
        end
        if (!(mem_req_o && mem_gnt_i)) begin
            tests++;
            fails++;
            $display("FAIL wait_grant: no grant within 50 cycles");
        end
    endtask

    task automatic wait_rvalid();
        for (int k = 0; k < 50; k++) begin
            if (mem_rvalid_i) break;
            cycle();
        end
        if (!mem_rvalid_i) begin
            tests++;
            fails++;
            $display("FAIL wait_rvalid: no response within 50 cycles");
        end
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_i      = 1'b1;
        redirect_addr_i = a;
        delivered.delete();
        cycle();
        redirect_i      = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        redirect_i      = 1'b0;
        redirect_addr_i = 32'h0;
        if_ready_i      = 1'b1;
        @(posedge clk);
        #2;
        cycle();
        cycle();
        check("rst_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_valid", {31'b0, if_valid_o}, 32'd0);
        check("rst_fault", {31'b0, if_fault_o}, 32'd0);
        check("rst_wait", {31'b0, if_wait_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_instr", if_instr_o, 32'd0);
        check("rst_pc", if_pc_o, 32'd0);
        check("rst_fault_addr", if_fault_addr_o, 32'd0);

        rst = 1'b0;
        #1;
        check("first_req", {31'b0, mem_req_o}, 32'd1);
        check("first_addr", mem_addr_o, 32'h1000_0000);
        delivered.delete();
        repeat (12) cycle();
        check("zw_pc0", dget(0), 32'h1000_0000);
        check("zw_pc1", dget(1), 32'h1000_0004);
        check("zw_pc2", dget(2), 32'h1000_0008);

        if_ready_i = 1'b0;
        repeat (10) cycle();
        check("stall_req", {31'b0, mem_req_o}, 32'd0);
        check("stall_valid", {31'b0, if_valid_o}, 32'd1);
        check("stall_wait", {31'b0, if_wait_o}, 32'd0);
        gnt_en     = 1'b0;
        if_ready_i = 1'b1;
        n0 = delivered.size();
        repeat (6) cycle();
        check("stall_drain", 32'(delivered.size() - n0), 32'd2);
        gnt_en = 1'b1;
        repeat (4) cycle();

        lat = 3;
        wait_grant();
        cycle();
        check("wait_pulse", {31'b0, if_wait_o}, 32'd1);
        redirect_to(32'h1000_0100);
        repeat (20) cycle();
        check("wait_redir_pc", dget(0), 32'h1000_0100);
        check("wait_redir_pc1", dget(1), 32'h1000_0104);
        lat = 0;

        repeat (4) cycle();
        wait_rvalid();
        redirect_to(32'h1000_0200);
        repeat (10) cycle();
        check("rvalid_redir_pc", dget(0), 32'h1000_0200);

        wait_grant();
        redirect_to(32'h1000_0300);
        repeat (10) cycle();
        check("gnt_redir_pc", dget(0), 32'h1000_0300);

        redirect_to(32'h1000_3FFC);
        repeat (20) cycle();
        check("top_count", 32'(delivered.size()), 32'd1);
        check("top_pc", dget(0), 32'h1000_3FFC);
        check("top_fault", {31'b0, if_fault_o}, 32'd1);
        check("top_fault_addr", if_fault_addr_o, 32'h1000_4000);
        check("top_noreq", {31'b0, mem_req_o}, 32'd0);

        redirect_to(32'h1000_0002);
        check("mis_fault", {31'b0, if_fault_o}, 32'd1);
        check("mis_fault_addr", if_fault_addr_o, 32'h1000_0002);
        check("mis_noreq", {31'b0, mem_req_o}, 32'd0);
        cycle();
        redirect_to(32'h1000_0000);
        repeat (10) cycle();
        check("recover_fault", {31'b0, if_fault_o}, 32'd0);
        check("recover_fault_addr", if_fault_addr_o, 32'd0);
        check("recover_pc0", dget(0), 32'h1000_0000);
        check("recover_pc1", dget(1), 32'h1000_0004);

        lat = 3;
        wait_grant();
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check("rerst_req", {31'b0, mem_req_o}, 32'd1);
        check("rerst_addr", mem_addr_o, 32'h1000_0000);
        lat = 0;
        delivered.delete();
        repeat (10) cycle();
        check("rerst_pc0", dget(0), 32'h1000_0000);
        check("rerst_pc1", dget(1), 32'h1000_0004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
